// File: rtl/trng_pkg.sv
// trng_pkg: state encoding and default parameters shared by the TRNG collector files.
package trng_pkg;

    typedef enum logic [1:0] {IDLE, WARMUP, RUN, FAIL} trng_state_t;

    localparam int DEF_WIDTH         = 32;
    localparam int DEF_FIFO_DEPTH    = 4;
    localparam int DEF_SAMPLE_DIV    = 4;
    localparam int DEF_WARMUP_CYCLES = 64;
    localparam int DEF_REP_LIMIT     = 32;

endpackage

// File: rtl/trng_fifo.sv
// trng_fifo: synchronous first-word-fall-through FIFO; rd_data_o reads zero while empty.
module trng_fifo
    import trng_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            push_data_i,
    input  logic                        pop_i,
    output logic [WIDTH-1:0]            rd_data_o,
    output logic                        rd_valid_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic do_push, do_pop;

    assign do_pop  = pop_i && level_q != '0;
    assign do_push = push_i && level_q != LW'(FIFO_DEPTH);

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q + LW'(do_push) - LW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign rd_valid_o = level_q != '0;
    assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o    = level_q;

endmodule

// File: rtl/trng_collector.sv
// trng_collector: samples the TRNG macro, von Neumann debiases, packs WIDTH-bit words into a FWFT FIFO.
// Define TRNG_HEALTH_EN to add the repetition-count health test and the FAIL state.
module trng_collector
    import trng_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int SAMPLE_DIV    = DEF_SAMPLE_DIV,
    parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
    parameter int REP_LIMIT     = DEF_REP_LIMIT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    output logic                        trng_en,
    input  logic                        trng_raw,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        health_fail
);
    localparam int SW = $clog2(SAMPLE_DIV + 1);
    localparam int WW = $clog2(WARMUP_CYCLES + 1);
    localparam int BW = $clog2(WIDTH);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    if (WIDTH < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        SAMPLE_DIV < 1 || WARMUP_CYCLES < 1 || REP_LIMIT < 1) begin : g_bad_params
        $error("trng_collector: illegal parameter set");
    end

    trng_state_t state_q, state_d;
    logic sync_q, raw_s_q;
    logic [WW-1:0] warm_q, warm_d;
    logic [SW-1:0] div_q, div_d;
    logic pair_q, pair_d, first_q, first_d;
    logic [WIDTH-2:0] word_q, word_d;
    logic [BW-1:0] bits_q, bits_d;
    logic [WIDTH-1:0] shift_w;
    logic full, clr, strobe, extract, push, rep_trip;

    assign full    = level == LW'(FIFO_DEPTH);
    assign clr     = state_q == IDLE || state_q == WARMUP;
    assign strobe  = state_q == RUN && div_q == SW'(SAMPLE_DIV - 1) && !full;
    assign extract = strobe && pair_q && first_q != raw_s_q;
    assign push    = extract && bits_q == BW'(WIDTH - 1);
    // The register only keeps WIDTH-1 bits; the newest bit completes the word on push.
    assign shift_w = {word_q, first_q};

`ifdef TRNG_HEALTH_EN
    localparam int RW = $clog2(REP_LIMIT + 1);
    logic [RW-1:0] rep_q, rep_d;
    logic prev_q, prev_d;

    always_comb begin
        prev_d = strobe ? raw_s_q : prev_q;
        rep_d  = state_q != RUN ? '0 :
                 !strobe ? rep_q :
                 (rep_q == '0 || raw_s_q != prev_q) ? RW'(1) : rep_q + 1'b1;
    end

    assign rep_trip = strobe && rep_d == RW'(REP_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_q  <= '0;
            prev_q <= 1'b0;
        end else begin
            rep_q  <= rep_d;
            prev_q <= prev_d;
        end
    end
`else
    assign rep_trip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        state_q <= reset ? IDLE : state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable) state_d = IDLE;
        else if (state_q == IDLE) state_d = WARMUP;
        else if (state_q == WARMUP && warm_q == WW'(WARMUP_CYCLES - 1)) state_d = RUN;
        else if (state_q == RUN && rep_trip) state_d = FAIL;
    end

    always_comb begin
        trng_en = state_q == WARMUP || state_q == RUN;
`ifdef TRNG_HEALTH_EN
        health_fail = state_q == FAIL;
`else
        health_fail = 1'b0;
`endif
    end

    always_comb begin
        warm_d  = state_q == WARMUP ? warm_q + 1'b1 : '0;
        div_d   = (state_q != RUN || div_q == SW'(SAMPLE_DIV - 1)) ? '0 : div_q + 1'b1;
        pair_d  = clr ? 1'b0 : strobe ? !pair_q : pair_q;
        first_d = clr ? 1'b0 : (strobe && !pair_q) ? raw_s_q : first_q;
        word_d  = clr ? '0 : extract ? shift_w[WIDTH-2:0] : word_q;
        bits_d  = (clr || push) ? '0 : extract ? bits_q + 1'b1 : bits_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 1'b0;
            raw_s_q <= 1'b0;
            warm_q  <= '0;
            div_q   <= '0;
            pair_q  <= 1'b0;
            first_q <= 1'b0;
            word_q  <= '0;
            bits_q  <= '0;
        end else begin
            sync_q  <= trng_raw;
            raw_s_q <= sync_q;
            warm_q  <= warm_d;
            div_q   <= div_d;
            pair_q  <= pair_d;
            first_q <= first_d;
            word_q  <= word_d;
            bits_q  <= bits_d;
        end
    end

    trng_fifo #(.WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (shift_w),
        .pop_i       (rd_ready),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .level_o     (level)
    );

endmodule

// File: tb/tb_trng_collector.sv
// tb_trng_collector: table-driven scoreboard bench for trng_collector.
// Health-test checks are compiled in only when TRNG_HEALTH_EN is defined.
module tb_trng_collector;

    typedef struct {
        logic [63:0] raw;
        int          junk;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0, reset = 1'b1, enable = 1'b0, trng_raw = 1'b0, rd_ready = 1'b0;
    logic trng_en, rd_valid, health_fail;
    logic [31:0] rd_data;
    logic [2:0] level;

    int n_vec = 0, n_bad = 0;
    bit samp_q[$];
    logic [31:0] sb[$];
    int fill_mode = 0;  // 0: 1100 pairs (discarded), 1: 1010 toggling, 2: constant 1
    bit stream_stop = 1'b0;
    vec_t tab[8];

    trng_collector #(
        .WIDTH(32), .FIFO_DEPTH(4), .SAMPLE_DIV(4), .WARMUP_CYCLES(64), .REP_LIMIT(32)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .trng_en(trng_en), .trng_raw(trng_raw),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .level(level),
        .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run exceeded its time limit after %0d vectors", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One sample per 4 cycles, first one held across the first strobe of RUN.
    task automatic stream();
        int k = 0;
        repeat (64) @(posedge clk);
        while (!stream_stop) begin
            #1;
            if (samp_q.size() != 0 && !k[0]) trng_raw = samp_q.pop_front();
            else begin
                trng_raw = fill_mode == 2 ? 1'b1 : fill_mode == 1 ? ~k[0] : ~k[1];
                k++;
            end
            repeat (4) @(posedge clk);
        end
    endtask

    task automatic queue_word(input vec_t v);
        for (int j = 0; j < v.junk; j++) begin
            samp_q.push_back(!j[0]);
            samp_q.push_back(!j[0]);
        end
        for (int i = 63; i >= 0; i--) samp_q.push_back(v.raw[i]);
        sb.push_back(v.exp);
    endtask

    task automatic start_session();
        @(posedge clk);
        #1 enable = 1'b1;
        @(posedge clk);
        fork stream(); join_none
    endtask

    task automatic wait_until_valid(input int bound, output int cyc);
        cyc = 0;
        while (!rd_valid && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        if (!rd_valid) cyc = -1;
    endtask

    task automatic wait_level(input logic [2:0] lvl, input int bound, output int cyc);
        cyc = 0;
        while (level !== lvl && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        if (level !== lvl) cyc = -1;
    endtask

    task automatic wait_drained(input int bound);
        for (int t = 0; t < bound && samp_q.size() != 0; t++) @(negedge clk);
    endtask

    task automatic pop_check(input string name);
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, got %h", name, rd_data);
        end else begin
            check({name, "_valid"}, 32'(rd_valid), 32'd1);
            check(name, rd_data, sb.pop_front());
        end
    endtask

    task automatic stop_stream();
        stream_stop = 1'b1;
        repeat (8) @(posedge clk);
        stream_stop = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_trng_en"}, 32'(trng_en), 32'd0);
        check({name, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({name, "_rd_data"}, rd_data, 32'd0);
        check({name, "_level"}, 32'(level), 32'd0);
        check({name, "_health"}, 32'(health_fail), 32'd0);
    endtask

    initial begin
        int cyc;
        logic [31:0] w;
        bit seen;
        tab[0] = '{64'hAAAA_AAAA_AAAA_AAAA, 0, 32'hFFFF_FFFF};
        tab[1] = '{64'hAAAA_AAAA_AAAA_AAAA, 0, 32'hFFFF_FFFF};
        tab[2] = '{64'h5555_5555_5555_5555, 2, 32'h0000_0000};
        tab[3] = '{64'h6666_6666_6666_6666, 0, 32'h5555_5555};
        tab[4] = '{64'h9999_9999_9999_9999, 1, 32'hAAAA_AAAA};
        tab[5] = '{64'h5659_5A65_6669_6A95, 0, 32'h1234_5678};
        tab[6] = '{64'hA6A9_99A6_9AA9_A9AA, 3, 32'hDEAD_BEEF};
        tab[7] = '{64'hA555_AAAA_A9A9_5556, 0, 32'hC0FF_EE01};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Table of words streamed back to back, consumer always ready.
        foreach (tab[i]) queue_word(tab[i]);
        rd_ready = 1'b1;
        @(posedge clk);
        #1 enable = 1'b1;
        @(negedge clk);
        check("trng_en_before_edge", 32'(trng_en), 32'd0);
        @(posedge clk);
        fork stream(); join_none
        @(negedge clk);
        check("trng_en_rise", 32'(trng_en), 32'd1);
        for (int i = 0; i < 8; i++) begin
            wait_until_valid(400, cyc);
            if (i == 0) check("first_word_time", 32'(cyc >= 318 && cyc <= 326), 32'd1);
            if (cyc < 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL table[%0d]: no word within 400 cycles, expected %h", i, tab[i].exp);
            end else begin
                pop_check($sformatf("table[%0d]", i));
                @(negedge clk);
            end
        end
        check("table_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure: fill the FIFO, hold it full, then drain on consecutive cycles.
        rd_ready = 1'b0;
        queue_word(tab[5]);
        queue_word(tab[6]);
        queue_word(tab[7]);
        queue_word(tab[3]);
        wait_drained(2000);
        fill_mode = 1;
        wait_level(3'd4, 600, cyc);
        check("bp_full_reached", 32'(cyc >= 0), 32'd1);
        repeat (200) @(negedge clk);
        check("bp_level_held", 32'(level), 32'd4);
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_level[%0d]", i), 32'(level), 32'(4 - i));
            pop_check($sformatf("bp_word[%0d]", i));
            if (i < 3) @(negedge clk);
        end
        @(posedge clk);
        #1 rd_ready = 1'b0;
        @(negedge clk);
        check("bp_drained", 32'(level), 32'd0);
        wait_until_valid(600, cyc);
        check("bp_resume", 32'(cyc >= 0), 32'd1);
        w = rd_data;
        check("bp_resume_word", 32'(w == 32'hFFFF_FFFF || w == 32'h0), 32'd1);

        enable = 1'b0;
        stop_stream();
        rd_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 rd_ready = 1'b0;
        fill_mode = 0;
        @(negedge clk);
        check("session_end_level", 32'(level), 32'd0);

        // Enable drop with one buffered word and a 16-bit partial word.
        queue_word(tab[7]);
        for (int i = 0; i < 16; i++) begin
            samp_q.push_back(1'b1);
            samp_q.push_back(1'b0);
        end
        start_session();
        wait_until_valid(500, cyc);
        check("drop_first_word", 32'(cyc >= 0), 32'd1);
        wait_drained(400);
        repeat (8) @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        check("drop_en_still_high", 32'(trng_en), 32'd1);
        @(negedge clk);
        check("drop_trng_en", 32'(trng_en), 32'd0);
        check("drop_level", 32'(level), 32'd1);
        stop_stream();
        @(negedge clk);
        check("drop_level_kept", 32'(level), 32'd1);
        queue_word(tab[5]);
        start_session();
        @(negedge clk);
        check("reenable_trng_en", 32'(trng_en), 32'd1);
        wait_level(3'd2, 500, cyc);
        check("reenable_word_time", 32'(cyc >= 316 && cyc <= 326), 32'd1);
        rd_ready = 1'b1;
        pop_check("drop_old_word");
        @(negedge clk);
        pop_check("drop_new_word");
        @(posedge clk);
        #1 rd_ready = 1'b0;

        // Reset mid-run with two buffered words.
        fill_mode = 1;
        wait_level(3'd2, 1200, cyc);
        check("reset_prefill", 32'(cyc >= 0), 32'd1);
        reset = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset");
        @(posedge clk);
        #1 reset = 1'b0;
        stop_stream();

        // Constant raw input.
        fill_mode = 2;
        start_session();
`ifdef TRNG_HEALTH_EN
        cyc = 0;
        while (!health_fail && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("health_time", 32'(health_fail && cyc <= 196), 32'd1);
        check("health_trng_en", 32'(trng_en), 32'd0);
        check("health_rd_valid", 32'(rd_valid), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        check("health_clear", 32'(health_fail), 32'd0);
`else
        seen = 1'b0;
        repeat (2000) begin
            @(negedge clk);
            if (rd_valid || health_fail) seen = 1'b1;
        end
        check("const_no_output", 32'(seen), 32'd0);
        check("const_trng_en", 32'(trng_en), 32'd1);
        enable = 1'b0;
`endif
        stop_stream();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
